// File: rtl/rs_pkg.sv
// Shared GF(256) constants and the table builder for the inverse/log ROM.
// Field polynomial x^8+x^4+x^3+x^2+1 (0x11D), primitive element 2.
package rs_pkg;

  localparam logic        TBL_INV = 1'b0;
  localparam logic        TBL_LOG = 1'b1;
  localparam int unsigned GF_W    = 8;
  localparam int unsigned ROM_AW  = 9;

  // Packed 256-entry table; entry a sits at bits [8a+7:8a].
  function automatic logic [256*GF_W-1:0] gf_tbl(input logic is_log);
    logic [7:0]           e;
    logic [7:0]           ex [256];
    logic [7:0]           lg [256];
    logic [256*GF_W-1:0]  t;
    e = 8'h01;
    for (int unsigned i = 0; i < 255; i++) begin
      ex[i[7:0]] = e;
      lg[e]      = i[7:0];
      e          = {e[6:0], 1'b0} ^ (e[7] ? 8'h1D : 8'h00);
    end
    ex[255] = 8'h01;
    lg[0]   = 8'hFF;
    t = '0;
    for (int unsigned a = 0; a < 256; a++) begin
      if (is_log == TBL_LOG)
        t[a*GF_W +: GF_W] = lg[a[7:0]];
      else if (a == 0)
        t[a*GF_W +: GF_W] = 8'h01;
      else
        t[a*GF_W +: GF_W] = ex[8'((255 - int'(lg[a[7:0]])) % 255)];
    end
    return t;
  endfunction

endpackage

// File: rtl/rs_rom_arb_rom.sv
// Combinational GF(256) inverse/log table ROM, addressed by {sel, arg}.
module rs_rom_arb_rom
  import rs_pkg::*;
(
  input  logic [ROM_AW-1:0] addr,
  output logic [GF_W-1:0]   data
);

  localparam logic [256*GF_W-1:0] INV_TBL = gf_tbl(TBL_INV);
  localparam logic [256*GF_W-1:0] LOG_TBL = gf_tbl(TBL_LOG);

  logic [10:0] bit_ofs;

  always_comb begin
    bit_ofs = {addr[7:0], 3'b000};
    data    = (addr[8] == TBL_LOG) ? LOG_TBL[bit_ofs +: GF_W] : INV_TBL[bit_ofs +: GF_W];
  end

endmodule

// File: rtl/rs_rom_arb.sv
// Round-robin arbiter sharing one GF(256) inverse/log ROM, fixed 2-cycle latency.
// Define RS_ROM_ARB_LOG_ZERO_CHK_EN to flag log(0) via rerr and zero its rdata.
module rs_rom_arb
  import rs_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      sel,
  input  logic [8*NREQ-1:0]    arg,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [GF_W-1:0]      rdata,
  output logic                 rerr
);

  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic            found;
  int unsigned     k;

  logic            s1_valid;
  logic            s1_sel;
  logic [GF_W-1:0] s1_arg;
  logic [IW-1:0]   s1_idx;
  logic [GF_W-1:0] rom_data;

  // Search starts one past the last winner; gnt is gated by rst_n so nothing
  // is granted while reset is held.
  always_comb begin
    gnt   = '0;
    gidx  = ptr;
    found = 1'b0;
    k     = 0;
    if (rst_n) begin
      for (int unsigned i = 1; i <= NREQ; i++) begin
        k = (int'(ptr) + i) % NREQ;
        if (!found && req[k]) begin
          found  = 1'b1;
          gnt[k] = 1'b1;
          gidx   = k[IW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IW'(NREQ - 1);
      s1_valid <= 1'b0;
      s1_sel   <= TBL_INV;
      s1_arg   <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= found;
      if (found) begin
        ptr    <= gidx;
        s1_sel <= sel[gidx];
        s1_arg <= arg[{gidx, 3'b000} +: GF_W];
        s1_idx <= gidx;
      end
    end
  end

  rs_rom_arb_rom u_rom (
    .addr ({s1_sel, s1_arg}),
    .data (rom_data)
  );

`ifdef RS_ROM_ARB_LOG_ZERO_CHK_EN
  logic log_zero;
  assign log_zero = (s1_sel == TBL_LOG) && (s1_arg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
      rerr   <= 1'b0;
    end else begin
      rvalid <= '0;
      rerr   <= 1'b0;
      if (s1_valid) begin
        rvalid[s1_idx] <= 1'b1;
        rdata          <= log_zero ? '0 : rom_data;
        rerr           <= log_zero;
      end
    end
  end
`else
  assign rerr = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (s1_valid) begin
        rvalid[s1_idx] <= 1'b1;
        rdata          <= rom_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_rom_arb.sv
// Scoreboard bench for rs_rom_arb (NREQ=4); honours RS_ROM_ARB_LOG_ZERO_CHK_EN.
module tb_rs_rom_arb;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   sel = '0;
  logic [8*N-1:0] arg = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rvalid;
  logic [7:0]     rdata;
  logic           rerr;

  rs_rom_arb #(.NREQ(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .sel    (sel),
    .arg    (arg),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .rerr   (rerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [7:0]  data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int unsigned last = N - 1;
  logic [N-1:0] prev_gnt = '0;
`ifdef RS_ROM_ARB_LOG_ZERO_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: carry-less multiply mod 0x11D, brute-force inverse/log.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned x = a, y = b, p = 0;
    while (y != 0) begin
      if (y & 1) p ^= x;
      x <<= 1;
      if (x & 'h100) x ^= 'h11D;
      y >>= 1;
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    if (a == 0) return 8'd1;
    for (int unsigned b = 1; b < 256; b++)
      if (gf_mul(a, b[7:0]) == 8'd1) return b[7:0];
    return 8'd0;
  endfunction

  function automatic logic [7:0] ref_log(input logic [7:0] a);
    logic [7:0] p = 8'd1;
    if (a == 0) return 8'd255;
    for (int unsigned n = 0; n < 255; n++) begin
      if (p == a) return n[7:0];
      p = gf_mul(p, 8'd2);
    end
    return 8'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, check grant and push expectations mid-cycle.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] s,
                      input logic [8*N-1:0] a);
    logic [N-1:0] eg;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; req = rq; sel = s; arg = a;
    @(negedge clk);
    eg = '0;
    if (!rst_n) begin
      last = N - 1;
    end else begin
      for (int unsigned i = 1; i <= N; i++) begin
        int unsigned c = (last + i) % N;
        if (eg == '0 && rq[c]) begin
          eg[c] = 1'b1;
          e.idx = c;
          e.due = cyc + 2;
          e.err = CHK_EN && s[c] && a[8*c +: 8] == 8'd0;
          if (!s[c])          e.data = ref_inv(a[8*c +: 8]);
          else if (e.err)     e.data = 8'd0;
          else                e.data = ref_log(a[8*c +: 8]);
          q.push_back(e);
          last = c;
        end
      end
    end
    check("gnt", 32'(gnt), 32'(eg));
    prev_gnt = gnt;
  endtask

  // Monitor: pops the scoreboard whenever a result strobe appears.
  logic [7:0] last_rdata = 8'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_rerr", 32'(rerr), 32'd0);
      q.delete();
      last_rdata = 8'd0;
    end else if (rvalid != '0) begin
      if (q.size() == 0) begin
        check("unexpected_rvalid", 32'(rvalid), 32'd0);
      end else begin
        exp_t e;
        logic [N-1:0] oh;
        e = q.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        check("rvalid", 32'(rvalid), 32'(oh));
        check("rdata", 32'(rdata), 32'(e.data));
        check("rerr", 32'(rerr), 32'(e.err));
        check("latency", 32'(cyc), 32'(e.due));
      end
      last_rdata = rdata;
    end else begin
      if (q.size() != 0 && q[0].due <= cyc) begin
        check("missing_rvalid", 32'(rvalid), 32'(1 << q[0].idx));
        void'(q.pop_front());
      end
      check("rdata_hold", 32'(rdata), 32'(last_rdata));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
  endtask

  initial begin
    do_reset();
    // Single requester 0: inv(2).
    step(1'b1, 4'b0001, 4'b0000, 32'h0000_0002);
    idle(3);
    // Two requesters alternating on log(3)/log(2).
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0011, 4'b0011, 32'h0000_0203);
    idle(3);
    // All four active: wrap and no repeated winner.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] pg;
      pg = prev_gnt;
      step(1'b1, 4'b1111, 4'b1010, {8'h00, 8'h80, 8'h01, 8'hFF});
      if (i > 0) begin
        checks++;
        if (gnt == pg) begin
          failures++;
          $display("FAIL repeat_grant: got %0h twice", gnt);
        end
      end
    end
    idle(3);
    // log(0) and inv(0).
    step(1'b1, 4'b0100, 4'b0100, 32'h0000_0000);
    step(1'b1, 4'b1000, 4'b0000, 32'h0000_0000);
    idle(3);
    // Reset in the middle of back-to-back grants.
    step(1'b1, 4'b0011, 4'b0011, 32'h0000_0505);
    step(1'b0, 4'b0011, 4'b0011, 32'h0000_0505);
    step(1'b0, 4'b0011, 4'b0011, 32'h0000_0505);
    step(1'b1, '0, '0, '0);
    idle(3);
    step(1'b1, 4'b0011, 4'b0000, 32'h0000_0709);
    idle(3);
    // Requester 1 withdraws while requester 0 wins.
    do_reset();
    step(1'b1, 4'b0011, 4'b0000, 32'h0000_1133);
    step(1'b1, 4'b0000, 4'b0000, 32'h0000_1133);
    idle(3);
    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] rq, s;
      logic [8*N-1:0] a;
      rq = N'($urandom);
      s  = N'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a[8*$urandom_range(0, N-1) +: 8] = 8'h00;
      step(($urandom_range(0, 63) != 0), rq, s, a);
    end
    idle(4);
    check("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_rom_arb.md
RS_ROM_ARB -- requirements
Module: rs_rom_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing the GF(256) table ROM (legal range 2..4).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req  input  NREQ  per-requester lookup request, held until granted.
REQ-005 SHALL have port sel  input  NREQ  per-requester table select: 0 = inverse, 1 = log.
REQ-006 SHALL have port arg  input  8*NREQ  per-requester field element, requester k at bits [8k+7:8k].
REQ-007 SHALL have port gnt  output  NREQ  one-hot combinational grant, same cycle as req.
REQ-008 SHALL have port rvalid  output  NREQ  one-hot registered result strobe.
REQ-009 SHALL have port rdata  output  8  shared result, meaningful only while some rvalid bit is high.
REQ-010 SHALL have port rerr  output  1  log-of-zero flag, qualified by rvalid.

Function
REQ-011 SHALL grant at most one requester per cycle; gnt[k] SHALL be 1 only if req[k]=1.
REQ-012 SHALL arbitrate round-robin: the search starts at (last granted index + 1) mod NREQ; the pointer SHALL update only on a cycle with a grant.
REQ-013 SHALL latch {sel, arg, index} of the granted requester at the end of grant cycle N as ROM address {sel, arg}.
REQ-014 SHALL register the ROM output at the end of cycle N+1; rvalid[index] and rdata SHALL be valid in cycle N+2 (fixed latency 2).
REQ-015 SHALL sustain one lookup per cycle with back-to-back grants and no bubbles.
REQ-016 SHALL hold rvalid=0 in any cycle whose corresponding grant cycle issued no grant; rdata SHALL hold its last value when rvalid=0.
REQ-017 SHALL return inverse table entries for sel=0; inv(0) SHALL return the table value 1.
REQ-018 SHALL return log table entries for sel=1; log(0) SHALL return the table value 255.
REQ-019 SHALL treat a req dropped before its grant as withdrawn, with no result produced.
REQ-020 SHALL NOT grant while rst_n=0.
REQ-021 SHALL make the pointer wrap from NREQ-1 to 0.

Reset
REQ-022 SHALL, on rst_n low, immediately drive gnt=0, rvalid=0, rdata=8'h00, rerr=0, and set the pointer to NREQ-1 so that requester 0 has first priority.
REQ-023 SHALL discard in-flight lookups on reset mid-operation; no rvalid SHALL appear for them after release.
REQ-024 SHALL accept requests from the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with RS_ROM_ARB_LOG_ZERO_CHK_EN defined, assert rerr with rvalid when the result is for sel=1, arg=0, and force rdata=8'h00 for that result.
REQ-026 SHALL, without RS_ROM_ARB_LOG_ZERO_CHK_EN, tie rerr to 0 and pass the raw table value 255 for log(0).

Structure
REQ-027 SHALL place the constants TBL_INV=1'b0, TBL_LOG=1'b1, GF_W=8 and ROM_AW=9 in the shared package rs_pkg.
REQ-028 SHALL instantiate the existing combinational inverse/log table ROM as its only sub-module (9-bit address {sel,arg}, 8-bit data), with no second copy.
REQ-029 SHALL keep arbitration, the address register and the result register inside rs_rom_arb, with no further sub-modules.

Verification
REQ-030 SHALL cover: single requester 0, sel=0, arg=8'h02 in cycle 0 -> gnt[0]=1 in cycle 0; rvalid[0]=1 and rdata=142 in cycle 2.
REQ-031 SHALL cover: req=2'b11 held for 4 cycles, sel=1, arg0=3, arg1=2 after reset -> grant order 0,1,0,1; rdata stream 25,1,25,1 each 2 cycles later.
REQ-032 SHALL cover: NREQ=4, all requesters active, pointer wrap -> grant order 0,1,2,3,0 with no two consecutive grants to one index.
REQ-033 SHALL cover: sel=1, arg=0 -> with the macro, rdata=0 and rerr=1; without it, rdata=255 and rerr=0.
REQ-034 SHALL cover: grants in cycles 0 and 1, rst_n pulsed low in cycle 1 -> rvalid=0 throughout and after release; the next request is granted to requester 0.
REQ-035 SHALL cover: req[1] asserted then dropped while requester 0 is granted -> no grant and no rvalid for requester 1.
